// File: rtl/vmac_pkg.sv
// Shared types and constants for the vector MAC accumulator.
//   prec_e      : precision tag carried alongside each multiplier product
//   result_t    : one finished dot-product result as stored in the result FIFO
//   lane_count  : number of active lanes for a given precision
package vmac_pkg;

    localparam int LANES      = 4;
    // Widest legal accumulator; the FIFO entry is sized for it so the struct
    // can live here and be shared by every ACC_W instance.
    localparam int ACC_W_MAX  = 96;
    localparam int DATA_W_MAX = LANES * ACC_W_MAX;

    typedef enum logic [1:0] {
        P8   = 2'b00,
        P16  = 2'b01,
        P32  = 2'b10,
        P32B = 2'b11
    } prec_e;

    typedef struct packed {
        logic [DATA_W_MAX-1:0] data;
        prec_e                 precision;
        logic                  sat;
    } result_t;

    function automatic int lane_count(input prec_e p);
        case (p)
            P8:      return 4;
            P16:     return 2;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/vmac_result_fifo.sv
// Two-entry synchronous FIFO holding finished results.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (accepted when not full, or full with a pop)
//   push_data  : result to store
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry (registered storage, no path from push)
//   full/empty : occupancy status
module vmac_result_fifo
    import vmac_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  result_t push_data,
    input  logic    pop,
    output result_t head,
    output logic    full,
    output logic    empty
);

    result_t    mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot being written, so a full FIFO
    // can still accept a push alongside a pop.
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: storage is reset here because the head feeds the outputs
            // directly and must read 0 after reset; only two entries exist.
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/vector_mac_accumulator.sv
// Per-lane saturating dot-product accumulator behind the vector multiplier.
//   clk, rst       : clock, synchronous active-high reset
//   in_valid       : product beat valid (aligned with multiplier output)
//   in_product     : 64-bit product word
//   in_precision   : precision tag selecting the lane split
//   in_last        : final beat of the current dot-product
//   out_valid      : FIFO head holds a result
//   out_ready      : consumer accepts the head
//   out_data       : four ACC_W lane accumulators, lane0 in the LSBs
//   out_precision  : precision of the head result
//   out_sat        : some lane of the head result saturated
//   err_overflow   : sticky, a result was dropped on a full FIFO
//   err_prec       : sticky, precision changed inside a sequence
//   clr_err        : clears both sticky flags (a set in the same cycle wins)
module vector_mac_accumulator
    import vmac_pkg::*;
#(
    parameter int ACC_W      = 72,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [63:0]          in_product,
    input  logic [1:0]           in_precision,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*ACC_W-1:0]   out_data,
    output logic [1:0]           out_precision,
    output logic                 out_sat,
    output logic                 err_overflow,
    output logic                 err_prec,
    input  logic                 clr_err
);

    localparam int SUM_W = ACC_W + 1;

    typedef enum logic {IDLE, ACCUM} state_e;

    state_e               state_q, state_d;
    prec_e                prec_q, prec_d, split_prec;
    logic [ACC_W-1:0]     acc_q [LANES];
    logic [ACC_W-1:0]     acc_d [LANES];
    logic [LANES-1:0]     sat_q, sat_d;
    logic [63:0]          lane_val [LANES];
    logic [SUM_W-1:0]     sum_w;
    logic [ACC_W-1:0]     sum_lane [LANES];
    logic [LANES*ACC_W-1:0] sum_flat;
    logic [LANES-1:0]     sum_sat, seq_sat;
    result_t              res_q, res_d;
    logic                 res_valid_q, res_valid_d;
    logic                 prec_mismatch, drop, pop;
    result_t              head;
    logic                 full, empty;

    // Mid-sequence beats are split with the latched precision even if the
    // tag has changed; the change is only flagged.
    assign split_prec    = (state_q == IDLE) ? prec_e'(in_precision) : prec_q;
    assign prec_mismatch = (state_q == ACCUM) && in_valid && (in_precision != prec_q);

    // Lane split and saturating add. A new sequence adds onto zero, which is
    // how IDLE "loads" the accumulators.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a value
        // unassigned and infers a latch.
        sum_flat = '0;
        sum_sat  = '0;
        sum_w    = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_val[k] = '0;
            if (k < lane_count(split_prec)) begin
                case (split_prec)
                    P8:      lane_val[k] = {48'b0, in_product[16*k +: 16]};
                    P16:     lane_val[k] = {32'b0, in_product[32*k +: 32]};
                    default: lane_val[k] = in_product;
                endcase
            end
            sum_w = (state_q == IDLE) ? SUM_W'(lane_val[k])
                                      : {1'b0, acc_q[k]} + SUM_W'(lane_val[k]);
            sum_sat[k]  = sum_w[ACC_W];
            sum_lane[k] = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
            sum_flat[k*ACC_W +: ACC_W] = sum_lane[k];
        end
        seq_sat = ((state_q == ACCUM) ? sat_q : '0) | sum_sat;
    end

    // FSM next state and accumulator/result updates.
    always_comb begin
        state_d     = state_q;
        prec_d      = prec_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        if (in_valid) begin
            if (state_q == IDLE) prec_d = prec_e'(in_precision);
            acc_d = sum_lane;
            sat_d = seq_sat;
            if (in_last) begin
                res_valid_d     = 1'b1;
                res_d.data      = DATA_W_MAX'(sum_flat);
                res_d.precision = split_prec;
                res_d.sat       = |seq_sat;
                for (int k = 0; k < LANES; k++) acc_d[k] = '0;
                sat_d   = '0;
                state_d = IDLE;
            end else begin
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prec_q      <= P8;
            for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
            sat_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prec_q      <= prec_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    // The finished result is registered once before entering the FIFO, so
    // nothing at the outputs depends combinationally on the inputs.
    assign pop  = out_ready;
    assign drop = res_valid_q & full & ~(pop & ~empty);

    vmac_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (res_valid_q),
        .push_data (res_q),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_overflow <= 1'b0;
            err_prec     <= 1'b0;
        end else begin
            if (drop)         err_overflow <= 1'b1;
            else if (clr_err) err_overflow <= 1'b0;
            if (prec_mismatch) err_prec <= 1'b1;
            else if (clr_err)  err_prec <= 1'b0;
        end
    end

    assign out_valid     = ~empty;
    assign out_data      = head.data[LANES*ACC_W-1:0];
    assign out_precision = head.precision;
    assign out_sat       = head.sat;

    if (LANES * ACC_W < DATA_W_MAX) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^head.data[DATA_W_MAX-1:LANES*ACC_W];
    end

endmodule

// File: tb/tb_vector_mac_accumulator.sv
module tb_vector_mac_accumulator;

    localparam int W  = 72;
    localparam int WB = 64;

    logic clk = 1'b0;
    logic rst, in_valid, in_last, out_ready, clr_err;
    logic [63:0] in_product;
    logic [1:0]  in_precision;

    logic          out_valid, out_sat, err_overflow, err_prec;
    logic [4*W-1:0] out_data;
    logic [1:0]    out_precision;
    logic           out_valid_b, out_sat_b, err_overflow_b, err_prec_b;
    logic [4*WB-1:0] out_data_b;
    logic [1:0]     out_precision_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vector_mac_accumulator #(.ACC_W(W), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_product(in_product),
        .in_precision(in_precision), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_precision(out_precision),
        .out_sat(out_sat), .err_overflow(err_overflow), .err_prec(err_prec),
        .clr_err(clr_err)
    );

    vector_mac_accumulator #(.ACC_W(WB), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_product(in_product),
        .in_precision(in_precision), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_precision(out_precision_b),
        .out_sat(out_sat_b), .err_overflow(err_overflow_b), .err_prec(err_prec_b),
        .clr_err(clr_err)
    );

    // Reference model for the ACC_W=72 instance: dot-product arithmetic on
    // wide integers plus a queue standing in for the two-slot result buffer.
    typedef struct {
        logic [4*W-1:0] data;
        logic [1:0]     prec;
        bit             sat;
    } res_t;

    bit           m_in_seq, m_pend, m_sat, m_err_ov, m_err_prec;
    logic [1:0]   m_prec;
    logic [127:0] m_acc [4];
    res_t         m_pend_res;
    res_t         m_q [$];

    task automatic model_edge();
        bit pop, drop, mism;
        int n, lw;
        logic [127:0] lane, s, maxv;
        if (rst) begin
            m_in_seq = 0; m_pend = 0; m_sat = 0; m_err_ov = 0; m_err_prec = 0;
            m_prec = 2'b00; m_q.delete();
            for (int k = 0; k < 4; k++) m_acc[k] = '0;
            return;
        end
        // result buffer: the result of a last beat arrives one edge later
        pop  = (m_q.size() > 0) && out_ready;
        drop = m_pend && (m_q.size() == 2) && !pop;
        if (pop) void'(m_q.pop_front());
        if (m_pend && !drop) m_q.push_back(m_pend_res);
        if (drop) m_err_ov = 1; else if (clr_err) m_err_ov = 0;
        // beat
        m_pend = 0;
        mism   = 0;
        if (in_valid) begin
            if (!m_in_seq) begin
                m_prec = in_precision;
                m_sat  = 0;
                for (int k = 0; k < 4; k++) m_acc[k] = '0;
            end else if (in_precision != m_prec) begin
                mism = 1;
            end
            n    = (m_prec == 2'b00) ? 4 : (m_prec == 2'b01) ? 2 : 1;
            lw   = 64 / n;
            maxv = (128'd1 << W) - 128'd1;
            for (int k = 0; k < n; k++) begin
                lane = (128'(in_product) >> (k * lw)) & ((128'd1 << lw) - 128'd1);
                s = m_acc[k] + lane;
                if (s > maxv) begin s = maxv; m_sat = 1; end
                m_acc[k] = s;
            end
            if (in_last) begin
                m_pend_res.data = '0;
                for (int k = 0; k < 4; k++) m_pend_res.data[k*W +: W] = m_acc[k][W-1:0];
                m_pend_res.prec = m_prec;
                m_pend_res.sat  = m_sat;
                m_pend   = 1;
                m_in_seq = 0;
            end else begin
                m_in_seq = 1;
            end
        end
        if (mism) m_err_prec = 1; else if (clr_err) m_err_prec = 0;
    endtask

    task automatic step(input bit r, input bit v, input logic [63:0] p,
                        input logic [1:0] pr, input bit last, input bit rdy, input bit clr);
        rst = r; in_valid = v; in_product = p; in_precision = pr;
        in_last = last; out_ready = rdy; clr_err = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 64'd0, 2'b00, 0, rdy, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 64'd0, 2'b00, 0, 0, 0);
        step(1, 0, 64'd0, 2'b00, 0, 0, 0);
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", out_data); end
        checks++; if (out_precision !== 2'b00) begin failures++; $display("FAIL rst_prec got=%0h exp=0", out_precision); end
        checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL rst_sat got=%0h exp=0", out_sat); end
        checks++; if ({err_overflow, err_prec} !== 2'b00) begin failures++; $display("FAIL rst_err got=%b exp=00", {err_overflow, err_prec}); end
        checks++; if ({out_valid_b, out_data_b, out_sat_b} !== '0) begin failures++; $display("FAIL rst_b got=%h exp=0", out_data_b); end
    endtask

    task automatic test_p8();
        logic [4*W-1:0] e;
        do_reset();
        e = '0; e[0 +: W] = 3; e[W +: W] = 6; e[2*W +: W] = 9; e[3*W +: W] = 12;
        step(0, 1, 64'h0004_0003_0002_0001, 2'b00, 0, 0, 0);
        step(0, 1, 64'h0004_0003_0002_0001, 2'b00, 0, 0, 0);
        step(0, 1, 64'h0004_0003_0002_0001, 2'b00, 1, 0, 0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL p8_early got=%0h exp=0", out_valid); end
        idle(0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL p8_valid got=%0h exp=1", out_valid); end
        checks++; if (out_data !== e) begin failures++; $display("FAIL p8_data got=%h exp=%h", out_data, e); end
        checks++; if ({out_precision, out_sat} !== 3'b000) begin failures++; $display("FAIL p8_prec_sat got=%b exp=000", {out_precision, out_sat}); end
        idle(0);
        checks++; if (out_data !== e || out_valid !== 1'b1) begin failures++; $display("FAIL p8_hold got=%h exp=%h", out_data, e); end
        idle(1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL p8_pop got=%0h exp=0", out_valid); end
    endtask

    task automatic test_p16();
        logic [4*W-1:0] e;
        do_reset();
        e = '0; e[0 +: W] = 3; e[W +: W] = 'h30;
        step(0, 1, 64'h0000_0010_0000_0001, 2'b01, 0, 0, 0);
        step(0, 1, 64'h0000_0020_0000_0002, 2'b01, 1, 0, 0);
        idle(0);
        checks++; if (out_data !== e) begin failures++; $display("FAIL p16_data got=%h exp=%h", out_data, e); end
        checks++; if (out_precision !== 2'b01) begin failures++; $display("FAIL p16_prec got=%0h exp=1", out_precision); end
    endtask

    task automatic test_saturation();
        logic [4*WB-1:0] eb;
        logic [4*W-1:0]  e;
        do_reset();
        eb = '0; eb[0 +: WB] = 64'hFFFF_FFFF_FFFF_FFFF;
        e  = '0; e[0 +: W] = 72'h1_FFFF_FFFF_FFFF_FFFE;
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 0, 0, 0);
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1, 0, 0);
        idle(0);
        checks++; if (out_data_b !== eb) begin failures++; $display("FAIL sat64_data got=%h exp=%h", out_data_b, eb); end
        checks++; if ({out_valid_b, out_sat_b} !== 2'b11) begin failures++; $display("FAIL sat64_flag got=%b exp=11", {out_valid_b, out_sat_b}); end
        checks++; if (out_data !== e || out_sat !== 1'b0) begin failures++; $display("FAIL sat72 got=%h/%0h exp=%h/0", out_data, out_sat, e); end
    endtask

    task automatic test_overflow();
        do_reset();
        step(0, 1, 64'd1, 2'b10, 1, 0, 0);
        step(0, 1, 64'd2, 2'b10, 1, 0, 0);
        step(0, 1, 64'd3, 2'b10, 1, 0, 0);
        idle(0);
        checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_err got=%0h exp=1", err_overflow); end
        checks++; if (out_valid !== 1'b1 || out_data !== (4*W)'(1)) begin failures++; $display("FAIL ovf_head1 got=%h exp=1", out_data); end
        idle(1);
        checks++; if (out_valid !== 1'b1 || out_data !== (4*W)'(2)) begin failures++; $display("FAIL ovf_head2 got=%h exp=2", out_data); end
        idle(1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%0h exp=0 (result 3 must be dropped)", out_valid); end
        checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0h exp=1", err_overflow); end
        step(0, 0, 64'd0, 2'b00, 0, 1, 1);
        checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%0h exp=0", err_overflow); end
    endtask

    task automatic test_prec_change();
        logic [4*W-1:0] e;
        do_reset();
        e = '0;
        for (int k = 0; k < 4; k++) e[k*W +: W] = 3;
        step(0, 1, 64'h0001_0001_0001_0001, 2'b00, 0, 0, 0);
        step(0, 1, 64'h0002_0002_0002_0002, 2'b01, 1, 0, 0);
        checks++; if (err_prec !== 1'b1) begin failures++; $display("FAIL prec_err got=%0h exp=1", err_prec); end
        idle(0);
        checks++; if (out_data !== e || out_precision !== 2'b00) begin failures++; $display("FAIL prec_split got=%h/%0h exp=%h/0", out_data, out_precision, e); end
        step(0, 0, 64'd0, 2'b00, 0, 1, 1);
        checks++; if (err_prec !== 1'b0) begin failures++; $display("FAIL prec_clr got=%0h exp=0", err_prec); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(0, 1, 64'd7, 2'b10, 0, 0, 0);
        step(1, 1, 64'd7, 2'b10, 0, 0, 0);
        idle(0);
        idle(0);
        checks++; if ({out_valid, out_data, out_precision, out_sat, err_overflow, err_prec} !== '0) begin
            failures++; $display("FAIL rstmid_zero got=%0h/%h exp=0", out_valid, out_data); end
        step(0, 1, 64'd5, 2'b10, 1, 0, 0);
        idle(0);
        checks++; if (out_valid !== 1'b1 || out_data !== (4*W)'(5)) begin failures++; $display("FAIL rstmid_next got=%h exp=5", out_data); end
    endtask

    task automatic test_random();
        logic [1:0] cur_prec;
        bit v, last, rdy, clr;
        do_reset();
        cur_prec = 2'b00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) cur_prec = 2'($urandom_range(3));
            v    = ($urandom_range(3) != 0);
            last = ($urandom_range(3) == 0);
            rdy  = ($urandom_range(9) < 6);
            clr  = ($urandom_range(19) == 0);
            step(0, v, {$urandom, $urandom}, cur_prec, last, rdy, clr);
            checks++;
            if (out_valid !== (m_q.size() > 0)) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%0h exp=%0d", i, out_valid, m_q.size() > 0);
            end else if (m_q.size() > 0) begin
                if (out_data !== m_q[0].data || out_precision !== m_q[0].prec || out_sat !== m_q[0].sat) begin
                    failures++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", i, out_data, m_q[0].data);
                end
            end
            checks++;
            if (err_overflow !== m_err_ov || err_prec !== m_err_prec) begin
                failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, {err_overflow, err_prec}, {m_err_ov, m_err_prec});
            end
        end
    endtask

    initial begin
        rst = 1; in_valid = 0; in_product = '0; in_precision = '0;
        in_last = 0; out_ready = 0; clr_err = 0;
        test_reset();
        test_p8();
        test_p16();
        test_saturation();
        test_overflow();
        test_prec_change();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
